// File: rtl/queue_output_schedule_if.sv
// Purpose: groups every non-clock signal of queue_output_schedule into one bundle.
//   master : the scheduler side (queue_output_schedule drives the o_/ov_ signals)
//   slave  : the environment side (queue-empty source, flow-table RAM, fragment buffer, free path)
// Signals:
//   i_sched_en          arbitration enable
//   iv_queue_empty[31:0] bit n = 0 -> queue n holds a complete packet
//   o_fmt_ram_rd / ov_fmt_ram_raddr[4:0] / iv_fmt_ram_rdata[18:0]  flow-table read port
//   o_frag_rd / ov_frag_queue_id / ov_frag_idx / ov_frag_flow_id / o_frag_last / i_frag_ready
//                        fragment read request handshake
//   ov_queue_id_free / o_queue_id_free_wr   queue release strobe
//   o_entry_err / o_free_err / ov_sent_pkt_cnt  status
interface queue_output_schedule_if;
  logic        i_sched_en;
  logic [31:0] iv_queue_empty;
  logic        o_fmt_ram_rd;
  logic [4:0]  ov_fmt_ram_raddr;
  logic [18:0] iv_fmt_ram_rdata;
  logic        o_frag_rd;
  logic [4:0]  ov_frag_queue_id;
  logic [5:0]  ov_frag_idx;
  logic [12:0] ov_frag_flow_id;
  logic        o_frag_last;
  logic        i_frag_ready;
  logic [4:0]  ov_queue_id_free;
  logic        o_queue_id_free_wr;
  logic        o_entry_err;
  logic        o_free_err;
  logic [15:0] ov_sent_pkt_cnt;

  modport master (
    input  i_sched_en, iv_queue_empty, iv_fmt_ram_rdata, i_frag_ready,
    output o_fmt_ram_rd, ov_fmt_ram_raddr, o_frag_rd, ov_frag_queue_id, ov_frag_idx,
           ov_frag_flow_id, o_frag_last, ov_queue_id_free, o_queue_id_free_wr,
           o_entry_err, o_free_err, ov_sent_pkt_cnt
  );

  modport slave (
    output i_sched_en, iv_queue_empty, iv_fmt_ram_rdata, i_frag_ready,
    input  o_fmt_ram_rd, ov_fmt_ram_raddr, o_frag_rd, ov_frag_queue_id, ov_frag_idx,
           ov_frag_flow_id, o_frag_last, ov_queue_id_free, o_queue_id_free_wr,
           o_entry_err, o_free_err, ov_sent_pkt_cnt
  );
endinterface

// File: rtl/queue_output_schedule.sv
// Purpose: round-robin output scheduler for the last-node reassembly path. Picks a queue that
//   holds a complete packet, reads its flow-table entry, issues one fragment read request per
//   cached fragment, releases the queue id and then waits for the queue to report empty.
//   One packet in flight at a time.
// Ports:
//   i_clk  clock
//   i_rst  asynchronous reset, active high
//   bus    queue_output_schedule_if.master (see interface header for the signal list)
// Parameters:
//   RAM_RD_LAT  flow-table read latency in cycles (1..3)
//   FREE_TMO    cycles allowed for the released queue to report empty (<= 15)
module queue_output_schedule #(
  parameter int unsigned RAM_RD_LAT = 2,
  parameter int unsigned FREE_TMO   = 15
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  queue_output_schedule_if.master       bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ENTRY,
    S_WAIT_DATA,
    S_SEND,
    S_FREE,
    S_WAIT_EMPTY
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  r_rr_ptr;
  logic [4:0]  r_cur_q;
  logic [1:0]  r_lat_cnt;
  logic [5:0]  r_frag_cnt;
  logic [12:0] r_flow_id;
  logic [5:0]  r_idx;
  logic [3:0]  r_tmo_cnt;
  logic        r_entry_err;
  logic        r_free_err;
  logic [15:0] r_sent_cnt;

  logic [4:0]  w_sel_q;
  logic        w_any;
  logic        w_start;
  logic        w_lat_done;
  logic [5:0]  w_rd_cnt;
  logic        w_last;
  logic        w_q_empty;
  logic        w_tmo;

  // Round-robin pick: scanning offsets from high to low lets the smallest offset
  // from the pointer win, i.e. the first non-empty queue at or after r_rr_ptr.
  always_comb begin
    w_sel_q = r_rr_ptr;
    for (int i = 31; i >= 0; i--) begin
      if (!bus.iv_queue_empty[r_rr_ptr + 5'(i)]) w_sel_q = r_rr_ptr + 5'(i);
    end
  end

  assign w_any      = ~&bus.iv_queue_empty;
  assign w_start    = bus.i_sched_en && w_any;
  assign w_lat_done = (r_lat_cnt == 2'(RAM_RD_LAT));
  assign w_rd_cnt   = bus.iv_fmt_ram_rdata[18:13];
  assign w_last     = (r_idx == r_frag_cnt - 6'd1);
  assign w_q_empty  = bus.iv_queue_empty[r_cur_q];
  assign w_tmo      = (r_tmo_cnt == 4'(FREE_TMO - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: every value written here gets a default first, so no path through the case leaves a latch.
    w_next                 = r_state;
    bus.o_fmt_ram_rd       = 1'b0;
    bus.o_frag_rd          = 1'b0;
    bus.o_queue_id_free_wr = 1'b0;
    case (r_state)
      S_IDLE:       if (w_start) w_next = S_RD_ENTRY;
      S_RD_ENTRY: begin
        bus.o_fmt_ram_rd = 1'b1;
        w_next           = S_WAIT_DATA;
      end
      S_WAIT_DATA:  if (w_lat_done) w_next = (w_rd_cnt == 6'd0) ? S_FREE : S_SEND;
      S_SEND: begin
        bus.o_frag_rd = 1'b1;
        if (bus.i_frag_ready && w_last) w_next = S_FREE;
      end
      S_FREE: begin
        bus.o_queue_id_free_wr = 1'b1;
        w_next                 = S_WAIT_EMPTY;
      end
      // Selection only happens in IDLE, so holding here is what keeps cur_q out of
      // arbitration until upstream has seen the release.
      S_WAIT_EMPTY: if (w_q_empty || w_tmo) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_rr_ptr    <= '0;
      r_cur_q     <= '0;
      r_lat_cnt   <= '0;
      r_frag_cnt  <= '0;
      r_flow_id   <= '0;
      r_idx       <= '0;
      r_tmo_cnt   <= '0;
      r_entry_err <= 1'b0;
      r_free_err  <= 1'b0;
      r_sent_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE:     if (w_start) r_cur_q <= w_sel_q;
        S_RD_ENTRY: r_lat_cnt <= 2'd1;
        S_WAIT_DATA: begin
          r_lat_cnt <= r_lat_cnt + 2'd1;
          if (w_lat_done) begin
            r_frag_cnt  <= w_rd_cnt;
            r_flow_id   <= bus.iv_fmt_ram_rdata[12:0];
            r_idx       <= '0;
            // Doubles as the error pulse (high during FREE) and the "do not count" flag.
            r_entry_err <= (w_rd_cnt == 6'd0);
          end
        end
        S_SEND: if (bus.i_frag_ready && !w_last) r_idx <= r_idx + 6'd1;
        S_FREE: begin
          r_entry_err <= 1'b0;
          if (!r_entry_err) r_sent_cnt <= r_sent_cnt + 16'd1;
          r_rr_ptr    <= r_cur_q + 5'd1;
          r_tmo_cnt   <= '0;
        end
        S_WAIT_EMPTY: begin
          r_tmo_cnt <= r_tmo_cnt + 4'd1;
          if (!w_q_empty && w_tmo) r_free_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ov_fmt_ram_raddr = r_cur_q;
  assign bus.ov_frag_queue_id = r_cur_q;
  assign bus.ov_frag_idx      = r_idx;
  assign bus.ov_frag_flow_id  = r_flow_id;
  assign bus.o_frag_last      = (r_state == S_SEND) && w_last;
  assign bus.ov_queue_id_free = r_cur_q;
  assign bus.o_entry_err      = r_entry_err;
  assign bus.o_free_err       = r_free_err;
  assign bus.ov_sent_pkt_cnt  = r_sent_cnt;

endmodule

// File: tb/tb_queue_output_schedule.sv
// Bench for queue_output_schedule: directed scenarios, a packet-level reference model
// (round-robin service plan computed from the loaded queue set) and a per-cycle compare process.
module tb_queue_output_schedule;
  localparam int LAT = 2;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst;

  queue_output_schedule_if bus();

  queue_output_schedule #(.RAM_RD_LAT(LAT), .FREE_TMO(TMO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  q;
    logic [5:0]  cnt;
    logic [12:0] flow;
  } pkt_t;

  logic [18:0] ft [32];
  pkt_t        plan_q [64];
  int          plan_n = 0;
  int          mptr   = 0;
  int          rel_cnt [32];
  logic [31:0] stuck  = '0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Flow-table RAM model: data valid exactly RAM_RD_LAT cycles after the strobe, junk otherwise.
  logic [2:0] rd_hist = '0;
  logic [4:0] addr_hist [3];
  always @(posedge clk) begin
    rd_hist      <= {rd_hist[1:0], bus.o_fmt_ram_rd};
    addr_hist[0] <= bus.ov_fmt_ram_raddr;
    addr_hist[1] <= addr_hist[0];
    addr_hist[2] <= addr_hist[1];
  end
  assign bus.iv_fmt_ram_rdata = rd_hist[LAT-1] ? ft[addr_hist[LAT-1]] : 19'h7FFFF;

  // ---------------- compare process ----------------
  int   cyc = 0, rd_n = 0, model_sent = 0;
  bit   act = 0, prev_stall = 0, prev_ferr = 0;
  pkt_t cur;
  int   exp_idx = 0, strobe_cyc = 0, free_cyc = 0, ferr_cyc = -1;
  int   n_strobe = 0, n_frag_acc = 0, n_free = 0, n_entry_err = 0, stall_cnt = 0;
  int   last_free_id = -1;
  int   served [$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("rst_outputs",
            {bus.o_fmt_ram_rd, bus.ov_fmt_ram_raddr, bus.o_frag_rd, bus.ov_frag_queue_id,
             bus.ov_frag_idx, bus.ov_frag_flow_id, bus.o_frag_last, bus.ov_queue_id_free,
             bus.o_queue_id_free_wr, bus.o_entry_err, bus.o_free_err, bus.ov_sent_pkt_cnt}, 64'd0);
      act = 0; rd_n = plan_n; model_sent = 0; prev_stall = 0; prev_ferr = 0;
    end else begin
      check("sent_cnt", bus.ov_sent_pkt_cnt, 64'(model_sent[15:0]));

      if (bus.o_fmt_ram_rd) begin
        check("strobe_while_active", act, 0);
        check("strobe_expected", rd_n < plan_n, 1);
        if (rd_n < plan_n) begin
          cur = plan_q[rd_n];
          rd_n++;
          check("fmt_raddr", bus.ov_fmt_ram_raddr, cur.q);
          act = 1; exp_idx = 0; strobe_cyc = cyc; n_strobe++;
          served.push_back(int'(bus.ov_fmt_ram_raddr));
        end
      end

      if (bus.o_frag_rd) begin
        check("frag_pkt_active", act && cur.cnt != 0, 1);
        if (act && cur.cnt != 0) begin
          check("frag_qid", bus.ov_frag_queue_id, cur.q);
          check("frag_idx", bus.ov_frag_idx, 64'(exp_idx));
          check("frag_flow", bus.ov_frag_flow_id, cur.flow);
          check("frag_last", bus.o_frag_last, exp_idx == int'(cur.cnt) - 1);
          if (exp_idx == 0 && !prev_stall) check("first_frag_latency", 64'(cyc - strobe_cyc), 64'(LAT + 1));
          if (bus.i_frag_ready) begin exp_idx++; n_frag_acc++; end
          else stall_cnt++;
        end
      end else if (prev_stall) begin
        check("frag_held", bus.o_frag_rd, 1);
      end
      prev_stall = bus.o_frag_rd && !bus.i_frag_ready;

      if (bus.o_entry_err) begin
        n_entry_err++;
        check("entry_err_with_free", bus.o_queue_id_free_wr, 1);
      end

      if (bus.o_queue_id_free_wr) begin
        check("free_pkt_active", act, 1);
        check("free_id", bus.ov_queue_id_free, cur.q);
        check("free_all_frags", 64'(exp_idx), 64'(cur.cnt));
        check("entry_err_at_free", bus.o_entry_err, cur.cnt == 0);
        if (cur.cnt != 0) model_sent++;
        act = 0; n_free++; last_free_id = int'(bus.ov_queue_id_free); free_cyc = cyc;
      end

      if (prev_ferr) check("free_err_sticky", bus.o_free_err, 1);
      else if (bus.o_free_err) ferr_cyc = cyc;
      prev_ferr = bus.o_free_err;
    end
  end

  // ---------------- driver helpers ----------------
  function automatic int rr_pick(input logic [31:0] set, input int ptr);
    for (int off = 0; off < 32; off++) begin
      int q;
      q = (ptr + off) % 32;
      if (set[q]) return q;
    end
    return -1;
  endfunction

  // Upstream free path: a released queue reports empty 3 cycles later unless marked stuck.
  task automatic step();
    if (bus.o_queue_id_free_wr && !stuck[bus.ov_queue_id_free]) rel_cnt[bus.ov_queue_id_free] = 3;
    @(posedge clk);
    #1;
    for (int q = 0; q < 32; q++) begin
      if (rel_cnt[q] > 0) begin
        rel_cnt[q]--;
        if (rel_cnt[q] == 0) bus.iv_queue_empty[q] = 1'b1;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic plan(input logic [31:0] m);
    logic [31:0] set;
    int q;
    set = m;
    while (set != 0) begin
      q = rr_pick(set, mptr);
      plan_q[plan_n] = '{q: 5'(q), cnt: ft[q][18:13], flow: ft[q][12:0]};
      plan_n++;
      set[q] = 1'b0;
      mptr = (q + 1) % 32;
    end
  endtask

  task automatic load(input logic [31:0] m);
    plan(m);
    bus.iv_queue_empty = bus.iv_queue_empty & ~m;
  endtask

  task automatic wait_frees(input int target, input string name);
    int b;
    b = 0;
    while (n_free < target && b < 400) begin step(); b++; end
    check(name, 64'(n_free), 64'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.iv_queue_empty = '1;
    for (int q = 0; q < 32; q++) rel_cnt[q] = 0;
    mptr = 0;
    steps(2);
    rst = 1'b0;
    steps(2);
  endtask

  initial begin
    int f0, s0, e0, st0, b;
    rst = 1'b1;
    bus.i_sched_en     = 1'b0;
    bus.iv_queue_empty = '1;
    bus.i_frag_ready   = 1'b1;
    for (int q = 0; q < 32; q++) begin ft[q] = '0; rel_cnt[q] = 0; end
    steps(3);
    rst = 1'b0;
    steps(2);
    check("post_reset_sent", bus.ov_sent_pkt_cnt, 0);
    check("post_reset_free_err", bus.o_free_err, 0);

    // 1: Q5, three fragments, flow 0x0A5
    ft[5] = {6'd3, 13'h0A5};
    f0 = n_frag_acc;
    bus.i_sched_en = 1'b1;
    load(32'h1 << 5);
    wait_frees(n_free + 1, "t1_free_done");
    steps(6);
    check("t1_frags", 64'(n_frag_acc - f0), 3);
    check("t1_free_id", 64'(last_free_id), 5);
    check("t1_sent", bus.ov_sent_pkt_cnt, 1);

    // 2: reset while a packet is stalled in SEND: no release strobe afterwards
    ft[12] = {6'd5, 13'h1FFF};
    bus.i_frag_ready = 1'b0;
    load(32'h1 << 12);
    b = 0;
    while (!bus.o_frag_rd && b < 50) begin step(); b++; end
    check("t2_reached_send", bus.o_frag_rd, 1);
    steps(3);
    f0 = n_free;
    do_reset();
    bus.i_frag_ready = 1'b1;
    steps(5);
    check("t2_no_free", 64'(n_free), 64'(f0));
    check("t2_sent_cleared", bus.ov_sent_pkt_cnt, 0);

    // 3: Q3, Q7, Q30 from pointer 0
    ft[3] = {6'd1, 13'h003}; ft[7] = {6'd2, 13'h007}; ft[30] = {6'd1, 13'h01E};
    s0 = served.size();
    load((32'h1 << 3) | (32'h1 << 7) | (32'h1 << 30));
    wait_frees(n_free + 3, "t3_free_done");
    steps(6);
    check("t3_order0", 64'(served[s0]),   3);
    check("t3_order1", 64'(served[s0+1]), 7);
    check("t3_order2", 64'(served[s0+2]), 30);

    // 4: Q0 and Q31 with pointer now at 31
    ft[0] = {6'd2, 13'h111}; ft[31] = {6'd1, 13'h1F1F};
    s0 = served.size();
    load(32'h1 | (32'h1 << 31));
    wait_frees(n_free + 2, "t4_free_done");
    steps(6);
    check("t4_order0", 64'(served[s0]),   31);
    check("t4_order1", 64'(served[s0+1]), 0);

    // 5: four fragments, ready low 10 cycles on idx1; sched_en drops mid-packet
    ft[20] = {6'd4, 13'h0C3};
    f0 = n_frag_acc; st0 = stall_cnt;
    load(32'h1 << 20);
    b = 0;
    while (!(bus.o_frag_rd && bus.ov_frag_idx == 6'd1) && b < 50) begin step(); b++; end
    check("t5_reached_idx1", bus.o_frag_rd && bus.ov_frag_idx == 6'd1, 1);
    bus.i_frag_ready = 1'b0;
    bus.i_sched_en   = 1'b0;
    steps(10);
    bus.i_frag_ready = 1'b1;
    wait_frees(n_free + 1, "t5_free_done");
    steps(6);
    check("t5_stall_cycles", 64'(stall_cnt - st0), 10);
    check("t5_frags", 64'(n_frag_acc - f0), 4);

    // 6: entry error on Q9
    ft[9] = '0;
    f0 = n_frag_acc; e0 = n_entry_err;
    bus.i_sched_en = 1'b1;
    load(32'h1 << 9);
    wait_frees(n_free + 1, "t6_free_done");
    steps(6);
    check("t6_entry_err_pulses", 64'(n_entry_err - e0), 1);
    check("t6_no_frags", 64'(n_frag_acc - f0), 0);
    check("t6_free_id", 64'(last_free_id), 9);
    check("t6_sent_unchanged", bus.ov_sent_pkt_cnt, 6);

    // 7: all empty with sched on, then Q4 present with sched off: no strobes either way
    s0 = n_strobe;
    steps(10);
    ft[4] = {6'd1, 13'h004};
    bus.i_sched_en = 1'b0;
    bus.iv_queue_empty[4] = 1'b0;
    steps(20);
    check("t7_no_strobe", 64'(n_strobe), 64'(s0));
    plan(32'h1 << 4);
    bus.i_sched_en = 1'b1;
    wait_frees(n_free + 1, "t7_free_done");
    steps(6);

    // 8: Q2 never reports empty after release
    ft[2] = {6'd2, 13'h0222};
    stuck[2] = 1'b1;
    load(32'h1 << 2);
    wait_frees(n_free + 1, "t8_free_done");
    bus.i_sched_en = 1'b0;
    b = 0;
    while (!bus.o_free_err && b < 40) begin step(); b++; end
    steps(1);
    check("t8_timeout_cycles", 64'(ferr_cyc - free_cyc), 16);
    steps(5);
    check("t8_free_err_held", bus.o_free_err, 1);
    stuck[2] = 1'b0;
    plan(32'h1 << 2);
    bus.i_sched_en = 1'b1;
    wait_frees(n_free + 1, "t8_reserve_done");
    steps(6);
    check("t8_reserved_q2", 64'(served[served.size()-1]), 2);
    check("t8_free_err_still", bus.o_free_err, 1);
    check("t8_sent", bus.ov_sent_pkt_cnt, 9);

    bus.i_sched_en = 1'b0;
    do_reset();
    check("final_free_err_cleared", bus.o_free_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
